// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered datapath bus multiplexer.
// Selects one of NSRC WIDTH-bit sources onto the shared bus using the
// per-source out-enable strobes, registers the result with a valid flag and
// the granted source index, and counts multi-driver conflicts for debug.
//
// Inputs are purely sampled every rising edge; there is no valid/ready
// handshake and no back-pressure. A strobe on src_out at edge k is reflected
// on bus_out/bus_valid/src_idx right after edge k.
//
// Optional build macro BUS_MUX_ROUND_ROBIN_EN: when defined, the grant scans
// cyclically from a rotating pointer that advances past the winner after each
// conflict cycle. When undefined, the lowest-indexed requester always wins and
// no pointer register exists.
module bus_mux_reg #(
    parameter int WIDTH     = 32,
    parameter int NSRC      = 24,
    parameter int HOLD_LAST = 0,
    parameter int CNT_W     = 8,
    localparam int SEL_W    = $clog2(NSRC)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [NSRC*WIDTH-1:0] bus_in,
    input  logic [NSRC-1:0]       src_out,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [SEL_W-1:0]      src_idx,
    output logic                  conflict,
    output logic                  conflict_sticky,
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             multi;

`ifdef BUS_MUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr;

    // Cyclic scan starting at ptr: the first requester found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (!grant_found && src_out[(int'(ptr) + k) % NSRC]) begin
                grant_found = 1'b1;
                grant_idx   = SEL_W'((int'(ptr) + k) % NSRC);
            end
        end
    end

    // Pointer moves just past the winner only when several sources competed.
    always_ff @(posedge clock) begin
        if (clear) begin
            ptr <= '0;
        end else if (multi) begin
            ptr <= (int'(grant_idx) == NSRC - 1) ? '0 : grant_idx + SEL_W'(1);
        end
    end
`else
    // Fixed priority: the lowest-indexed requester wins (legacy R0-first).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (!grant_found && src_out[i]) begin
                grant_found = 1'b1;
                grant_idx   = SEL_W'(i);
            end
        end
    end
`endif

    // Slice of the winning source and two-or-more-drivers detection.
    always_comb begin
        grant_data = bus_in[int'(grant_idx)*WIDTH +: WIDTH];
        multi      = |(src_out & (src_out - NSRC'(1)));
    end

    // Registered bus stage: winner's data, or idle value when nobody drives.
    always_ff @(posedge clock) begin
        if (clear) begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
            src_idx   <= '0;
        end else if (grant_found) begin
            bus_out   <= grant_data;
            bus_valid <= 1'b1;
            src_idx   <= grant_idx;
        end else begin
            bus_valid <= 1'b0;
            if (HOLD_LAST == 0) begin
                bus_out <= '0;
            end
        end
    end

    // Conflict pulse, sticky flag and saturating counter; a conflict beats err_clr.
    always_ff @(posedge clock) begin
        if (clear) begin
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else begin
            conflict <= multi;
            if (multi) begin
                conflict_sticky <= 1'b1;
                if (err_clr) begin
                    conflict_cnt <= CNT_W'(1);
                end else if (conflict_cnt != CNT_MAX) begin
                    conflict_cnt <= conflict_cnt + CNT_W'(1);
                end
            end else if (err_clr) begin
                conflict_sticky <= 1'b0;
                conflict_cnt    <= '0;
            end
        end
    end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of NSRC WIDTH-bit sources onto the shared datapath bus, using per-source out-enable strobes from the control unit.
- Adds a registered output stage with a valid flag and reports the selected source index.
- Detects and counts multi-driver conflicts for debug. Sits between the register file / special registers (HI, LO, Z, PC, MDR, In.Port, C) and all bus consumers.

Parameters:
- WIDTH, 32, data width of each source and of the bus.
- NSRC, 24, number of bus sources; must be 2..64.
- HOLD_LAST, 0, 1 = bus_out keeps its last driven value when no source is enabled; 0 = bus_out returns to 0.
- CNT_W, 8, width of the saturating conflict counter.
- SEL_W (localparam), clog2(NSRC), width of the source index.

Ports:
- clock, in, 1, rising-edge clock.
- clear, in, 1, synchronous active-high reset.
- bus_in, in, NSRC*WIDTH, flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- src_out, in, NSRC, out-enable strobes; bit i requests source i.
- err_clr, in, 1, clears conflict_sticky and conflict_cnt.
- bus_out, out, WIDTH, registered bus value.
- bus_valid, out, 1, 1 when bus_out was driven by a source in the previous cycle.
- src_idx, out, SEL_W, index of the granted source.
- conflict, out, 1, one-cycle registered pulse: two or more src_out bits were set.
- conflict_sticky, out, 1, latched conflict flag.
- conflict_cnt, out, CNT_W, saturating count of conflict cycles.

Behaviour:
- Interface: one clock, clock; clear is synchronous active-high; all state updates only on the rising edge of clock.
- Reset (clear=1 at an edge):
  - bus_out=0, bus_valid=0, src_idx=0, conflict=0, conflict_sticky=0, conflict_cnt=0, round-robin pointer=0.
  - clear overrides every other input.
- Latency: one cycle. src_out and bus_in sampled at edge k appear on the outputs after edge k.
- Grant (default, fixed priority): the lowest-indexed set bit of src_out wins; this matches the legacy R0-first ordering.
- Grant present:
  - bus_out = the granted source's slice, bus_valid=1, src_idx = granted index.
- No bits set:
  - bus_valid=0; src_idx holds.
  - bus_out = 0 if HOLD_LAST=0, otherwise it holds its previous value.
- Conflict (popcount(src_out) >= 2):
  - The grant still proceeds per the arbitration rule; bus_out is never an OR of sources.
  - conflict=1 for exactly that registered cycle.
  - conflict_sticky sets.
  - conflict_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- err_clr:
  - With no conflict in the same cycle: conflict_sticky=0, conflict_cnt=0 next cycle.
  - Simultaneous with a conflict: the conflict wins, giving conflict_sticky=1 and conflict_cnt=1.
- Clear during a conflict or a transfer: reset values take effect; no partial update.
- Inputs are purely sampled. The block holds no handshake; control must assert src_out for the cycle in which the bus is consumed, plus one cycle of latency.

Optional Feature:
- Macro: BUS_MUX_ROUND_ROBIN_EN.
- Defined:
  - Priority rotates using pointer ptr (SEL_W bits, reset 0).
  - Grant = first set bit found scanning cyclically from ptr upward.
  - After a conflict cycle, ptr = (granted index + 1) mod NSRC.
  - After a non-conflict cycle, ptr holds.
  - Single-driver behaviour is identical to fixed priority.
- Undefined: fixed lowest-index priority; no pointer register exists.

Test Plan:
- Reset/idle: clear=1 for 2 cycles with src_out=0x000001 and bus_in[0+:32]=0xDEADBEEF -> all outputs 0; after release, the next cycle gives bus_out=0xDEADBEEF, bus_valid=1, src_idx=0.
- Single driver sweep: for each i in 0..23, src_out=1<<i with source i=0x1000+i -> one cycle later bus_out=0x1000+i, src_idx=i, conflict=0, conflict_cnt=0.
- Idle hold: HOLD_LAST=1, drive source 5=0xA5A5A5A5, then src_out=0 -> bus_out stays 0xA5A5A5A5 with bus_valid=0; with HOLD_LAST=0, bus_out=0.
- Conflict: src_out=(1<<3)|(1<<7) for one cycle -> bus_out=source 3, conflict pulse of 1 cycle, sticky=1, cnt=1. Repeat for 300 cycles with CNT_W=8 -> cnt=255, no wrap.
- err_clr race: err_clr=1 alone -> sticky=0, cnt=0. err_clr=1 in the same cycle as a conflict -> sticky=1, cnt=1.
- Round-robin (macro defined): hold src_out=(1<<2)|(1<<9) for 4 cycles -> src_idx sequence 2,9,2,9. A subsequent single driver at 2 -> src_idx=2 and the pointer is unchanged.
